hz_tone_gen: RTL and testbench

- Square-wave tone source: the other end of the mic-signal Hz counter.
- Converts a 10-bit frequency word (Hz) into a square wave on `sq_out` at that frequency.
- Used for two purposes: to drive the buzzer/speaker path, and to loop back into the Hz counter for self-test.
- Uses a Bresenham-style phase accumulator, so the average frequency is exact for any Hz value with no divider.

---
 rtl/hz_tone_pkg.sv | 24 ++
 rtl/hz_phase_acc.sv | 44 ++++
 rtl/hz_tone_gen.sv | 141 ++++++++++++++
 tb/tb_hz_tone_gen.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hz_tone_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hz_tone_pkg
// Brief    : Shared state encoding, default widths and accumulator sizing
//            for the square-wave tone generator.
// Revision : 1.0
// ============================================================================
package hz_tone_pkg;

    localparam int HZ_W_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Wide enough for acc + 2*hz, which stays below 2*CLK_HZ.
    function automatic int acc_width(input int clk_hz);
        return $clog2(clk_hz) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hz_phase_acc.sv
`default_nettype none
// ============================================================================
// Module   : hz_phase_acc
// Brief    : Bresenham phase accumulator; tick marks each half-period boundary.
// Revision : 1.0
// ============================================================================
module hz_phase_acc
    import hz_tone_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int HZ_W   = HZ_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            en,
    input  logic [HZ_W-1:0] hz,
    output logic            tick
);

    localparam int ACC_W = acc_width(CLK_HZ);
    localparam logic [ACC_W-1:0] c_clk_hz = ACC_W'(CLK_HZ);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_step;
    logic [ACC_W-1:0] w_sum;

    // Two increments per output period: one per edge of the square wave.
    assign w_step = ACC_W'(hz) << 1;
    assign w_sum  = r_acc + w_step;
    assign tick   = en && (w_sum >= c_clk_hz);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (clear) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= tick ? (w_sum - c_clk_hz) : w_sum;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hz_tone_gen.sv
`default_nettype none
// ============================================================================
// Module   : hz_tone_gen
// Brief    : Square-wave tone source at hz_in Hz with clean stop (no runt).
//            HZ_TONE_GEN_EDGE_COUNT_EN adds a saturating rising-edge counter.
// Revision : 1.0
// ============================================================================
module hz_tone_gen
    import hz_tone_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int HZ_W   = HZ_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stop,
    input  logic [HZ_W-1:0] hz_in,
    output logic            sq_out,
    output logic            busy,
`ifdef HZ_TONE_GEN_EDGE_COUNT_EN
    output logic [HZ_W-1:0] edge_cnt,
`endif
    output logic            done
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [HZ_W-1:0] r_hz;
    logic            r_sq;
    logic            r_done;
    logic            w_sq_nxt;
    logic            w_done_nxt;
    logic            w_accept;
    logic            w_run;
    logic            w_tick;

    assign w_run    = (r_state != IDLE);
    assign w_accept = (r_state == IDLE) && start && (hz_in != '0);

    hz_phase_acc #(
        .CLK_HZ (CLK_HZ),
        .HZ_W   (HZ_W)
    ) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_accept),
        .en    (w_run),
        .hz    (r_hz),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sq_nxt    = r_sq;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = RUN;
                    w_sq_nxt    = 1'b1;
                end
            end
            RUN: begin
                if (stop && !r_sq) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else if (stop && w_tick) begin
                    // The toggle that ends the high phase coincides with stop.
                    w_state_nxt = IDLE;
                    w_sq_nxt    = 1'b0;
                    w_done_nxt  = 1'b1;
                end else if (stop) begin
                    w_state_nxt = DRAIN;
                end else if (w_tick) begin
                    w_sq_nxt = !r_sq;
                end
            end
            DRAIN: begin
                if (w_tick) begin
                    w_state_nxt = IDLE;
                    w_sq_nxt    = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_sq_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sq   <= 1'b0;
            r_done <= 1'b0;
            r_hz   <= '0;
        end else begin
            r_sq   <= w_sq_nxt;
            r_done <= w_done_nxt;
            if (w_accept) begin
                r_hz <= hz_in;
            end
        end
    end

    assign sq_out = r_sq;
    assign done   = r_done;
    assign busy   = w_run;

`ifdef HZ_TONE_GEN_EDGE_COUNT_EN
    logic            r_sq_d;
    logic [HZ_W-1:0] r_edge_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sq_d     <= 1'b0;
            r_edge_cnt <= '0;
        end else begin
            r_sq_d <= r_sq;
            if (w_accept) begin
                r_edge_cnt <= '0;
            end else if (w_run && r_sq && !r_sq_d && (r_edge_cnt != '1)) begin
                r_edge_cnt <= r_edge_cnt + HZ_W'(1);
            end
        end
    end

    assign edge_cnt = r_edge_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hz_tone_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_hz_tone_gen
// Brief    : Directed self-checking bench for hz_tone_gen (CLK_HZ=100).
// Revision : 1.0
// ============================================================================
module tb_hz_tone_gen;

    localparam int CLK_HZ = 100;
    localparam int HZ_W   = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            stop;
    logic [HZ_W-1:0] hz_in;
    wire             sq_out;
    wire             busy;
    wire             done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

`ifdef HZ_TONE_GEN_EDGE_COUNT_EN
    wire [HZ_W-1:0] ec1;
    logic           start2;
    logic           stop2;
    logic [7:0]     hz2;
    wire            sq2;
    wire            busy2;
    wire            done2;
    wire [7:0]      ec2;

    hz_tone_gen #(.CLK_HZ(1000), .HZ_W(8)) u_dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start2),
        .stop     (stop2),
        .hz_in    (hz2),
        .sq_out   (sq2),
        .busy     (busy2),
        .edge_cnt (ec2),
        .done     (done2)
    );
`endif

    hz_tone_gen #(.CLK_HZ(CLK_HZ), .HZ_W(HZ_W)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .hz_in    (hz_in),
        .sq_out   (sq_out),
        .busy     (busy),
`ifdef HZ_TONE_GEN_EDGE_COUNT_EN
        .edge_cnt (ec1),
`endif
        .done     (done)
    );

    task automatic cleanup(input string tag);
        logic seen;
        seen = 1'b0;
        stop = 1'b1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            stop = 1'b0;
            if (done === 1'b1) seen = 1'b1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s_cleanup done never seen (got 0, expected 1)", tag);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; hz_in = '0;
`ifdef HZ_TONE_GEN_EDGE_COUNT_EN
        start2 = 1'b0; stop2 = 1'b0; hz2 = '0;
`endif
        repeat (3) @(negedge clk);
        tests++; if (sq_out !== 1'b0) begin fails++; $display("FAIL reset_sq got=%b exp=0", sq_out); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if ({sq_out, busy, done} !== 3'b000) begin fails++; $display("FAIL reset_idle got=%b exp=000", {sq_out, busy, done}); end
`ifdef HZ_TONE_GEN_EDGE_COUNT_EN
        tests++; if (ec1 !== '0) begin fails++; $display("FAIL reset_edge_cnt got=%0d exp=0", ec1); end
`endif
    endtask

    // hz=10 at CLK_HZ=100: high for edges 0..4, low 5..9, and so on.
    task automatic test_basic();
        logic exp;
        hz_in = 5'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++; if (sq_out !== 1'b1) begin fails++; $display("FAIL basic_rise got=%b exp=1", sq_out); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy got=%b exp=1", busy); end
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            exp = ((i / 5) % 2) == 0;
            tests++; if (sq_out !== exp) begin fails++; $display("FAIL basic_wave edge=%0d got=%b exp=%b", i, sq_out, exp); end
        end
    endtask

    // Continues from test_basic: high phase began at edge 20.
    task automatic test_stop_high();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        tests++; if ({busy, sq_out, done} !== 3'b110) begin fails++; $display("FAIL drain_e22 got=%b exp=110", {busy, sq_out, done}); end
        start = 1'b1; hz_in = 5'd7;
        @(negedge clk);
        start = 1'b0;
        tests++; if ({busy, sq_out, done} !== 3'b110) begin fails++; $display("FAIL drain_e23 got=%b exp=110", {busy, sq_out, done}); end
        @(negedge clk);
        tests++; if ({busy, sq_out, done} !== 3'b110) begin fails++; $display("FAIL drain_e24 got=%b exp=110", {busy, sq_out, done}); end
        @(negedge clk);
        tests++; if ({busy, sq_out, done} !== 3'b001) begin fails++; $display("FAIL drain_end got=%b exp=001", {busy, sq_out, done}); end
        @(negedge clk);
        tests++; if ({busy, sq_out, done} !== 3'b000) begin fails++; $display("FAIL drain_after got=%b exp=000", {busy, sq_out, done}); end
    endtask

    task automatic test_stop_low();
        hz_in = 5'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        tests++; if (sq_out !== 1'b0) begin fails++; $display("FAIL stoplow_pre got=%b exp=0", sq_out); end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        tests++; if ({busy, sq_out, done} !== 3'b001) begin fails++; $display("FAIL stoplow_done got=%b exp=001", {busy, sq_out, done}); end
        @(negedge clk);
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL stoplow_pulse got=%b exp=0", done); end
    endtask

    task automatic test_zero_and_start_stop();
        hz_in = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests++; if ({busy, sq_out, done} !== 3'b000) begin fails++; $display("FAIL zero_hz cyc=%0d got=%b exp=000", i, {busy, sq_out, done}); end
            @(negedge clk);
        end
        hz_in = 5'd10; start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        tests++; if ({busy, sq_out, done} !== 3'b110) begin fails++; $display("FAIL start_wins got=%b exp=110", {busy, sq_out, done}); end
        cleanup("startwins");
    endtask

    // hz=3: 6 per step, toggles at floor(6n/100) increments -> phases of 16/17.
    task automatic test_fractional();
        logic prev;
        int   last;
        int   rises;
        hz_in = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        prev = 1'b1; last = 0; rises = 0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (sq_out !== prev) begin
                if (sq_out === 1'b1) rises++;
                tests++;
                if ((n - last) != 16 && (n - last) != 17) begin
                    fails++; $display("FAIL frac_phase edge=%0d got=%0d exp=16or17", n, n - last);
                end
                last = n;
                prev = sq_out;
            end
        end
        tests++; if (rises != 9) begin fails++; $display("FAIL frac_rises got=%0d exp=9", rises); end
        cleanup("frac");
    endtask

    task automatic test_ignore_midrun_and_async_reset();
        logic exp;
        hz_in = 5'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 21; i++) begin
            @(negedge clk);
            exp = ((i / 5) % 2) == 0;
            tests++; if (sq_out !== exp) begin fails++; $display("FAIL midrun_wave edge=%0d got=%b exp=%b", i, sq_out, exp); end
            if (i == 2) begin hz_in = 5'd20; start = 1'b1; end
            if (i == 3) start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        tests++; if ({busy, sq_out} !== 2'b00) begin fails++; $display("FAIL async_reset got=%b exp=00", {busy, sq_out}); end
        @(negedge clk);
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL async_nodone got=%b exp=0", done); end
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if ({busy, sq_out, done} !== 3'b000) begin fails++; $display("FAIL async_after got=%b exp=000", {busy, sq_out, done}); end
    endtask

`ifdef HZ_TONE_GEN_EDGE_COUNT_EN
    // CLK_HZ=1000, hz=25: 999 run edges give 49 toggles, low, 25 rises total.
    task automatic test_edge_count();
        logic seen;
        hz2 = 8'd25; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        tests++; if (ec2 !== 8'd0) begin fails++; $display("FAIL ec_start got=%0d exp=0", ec2); end
        repeat (999) @(negedge clk);
        stop2 = 1'b1;
        @(negedge clk);
        stop2 = 1'b0;
        tests++; if ({busy2, sq2, done2} !== 3'b001) begin fails++; $display("FAIL ec_stop got=%b exp=001", {busy2, sq2, done2}); end
        tests++; if (ec2 !== 8'd25) begin fails++; $display("FAIL ec_count got=%0d exp=25", ec2); end
        repeat (2) @(negedge clk);
        tests++; if (ec2 !== 8'd25) begin fails++; $display("FAIL ec_hold got=%0d exp=25", ec2); end
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        tests++; if (ec2 !== 8'd0) begin fails++; $display("FAIL ec_clear got=%0d exp=0", ec2); end
        @(negedge clk);
        tests++; if (ec2 !== 8'd1) begin fails++; $display("FAIL ec_first got=%0d exp=1", ec2); end
        stop2 = 1'b1; seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            stop2 = 1'b0;
            if (done2 === 1'b1) seen = 1'b1;
        end
        tests++; if (!seen) begin fails++; $display("FAIL ec_cleanup got=0 exp=1"); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stop_high();
        test_stop_low();
        test_zero_and_start_stop();
        test_fractional();
        test_ignore_midrun_and_async_reset();
`ifdef HZ_TONE_GEN_EDGE_COUNT_EN
        test_edge_count();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
